// File: rtl/four_12_12_st1_in_ser.sv
`default_nettype none
// ============================================================================
// Module      : four_12_12_st1_in_ser
// Description : Upstream feeder for the stage-1 controller's stage_1_data
//               stream. Accepts one LANES-wide vector of WIDTH-bit elements
//               per handshake into a 2-slot ping-pong buffer and serializes
//               each vector one lane per cycle, lane 0 first, with
//               stage_1_data_fst marking lane 0. Back-to-back frames are
//               emitted without bubbles.
// Ports       :
//   clk               in   1            clock, all state on posedge
//   reset             in   1            synchronous active-high reset
//   vec_in            in   WIDTH*LANES  input vector, lane i at [i*WIDTH +: WIDTH]
//   vec_in_vld        in   1            vec_in valid
//   vec_in_rdy        out  1            a buffer slot is free
//   stage_1_data      out  WIDTH        serialized element
//   stage_1_data_vld  out  1            element valid
//   stage_1_data_fst  out  1            element is lane 0 of its frame
//   stage_1_data_rdy  in   1            downstream ready
//   frame_count       out  FCNT_W       completed frames (wrapping)
//   busy              out  1            at least one slot occupied
// Revision    : 1.0 - initial release
// ============================================================================
module four_12_12_st1_in_ser #(
    parameter int WIDTH  = 32,
    parameter int LANES  = 12,
    parameter int CNT_W  = 4,
    parameter int FCNT_W = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH*LANES-1:0]   vec_in,
    input  logic                     vec_in_vld,
    output logic                     vec_in_rdy,
    output logic [WIDTH-1:0]         stage_1_data,
    output logic                     stage_1_data_vld,
    output logic                     stage_1_data_fst,
    input  logic                     stage_1_data_rdy,
    output logic [FCNT_W-1:0]        frame_count,
    output logic                     busy
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam logic [0:0]       S_IDLE      = 1'b0;
    localparam logic [0:0]       S_SEND      = 1'b1;
    localparam logic [CNT_W-1:0] c_last_lane = CNT_W'(LANES - 1);
    localparam logic [1:0]       c_occ_full  = 2'd2;
    localparam logic [1:0]       c_occ_empty = 2'd0;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [0:0]        r_state;
    logic [0:0]        w_state_next;
    logic [1:0]        r_occ;
    logic [1:0]        w_occ_next;
    logic              r_wr_ptr;
    logic              r_rd_ptr;
    logic [CNT_W-1:0]  r_lane;
    logic [FCNT_W-1:0] r_frame_count;
    logic [WIDTH-1:0]  r_slot [2][LANES];

    logic              w_accept;
    logic              w_xfer;
    logic              w_last;
    logic [WIDTH-1:0]  w_lanes [LANES];
    logic [WIDTH-1:0]  w_lane_data;

    // Unpack the flat input vector into per-lane words.
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign w_lanes[gi] = vec_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Next-state and handshake decode
    // ------------------------------------------------------------------
    always_comb begin
        w_accept     = 1'b0;
        w_xfer       = 1'b0;
        w_last       = 1'b0;
        w_occ_next   = r_occ;
        w_state_next = r_state;

        // Ready depends only on registered occupancy, so a full buffer
        // makes an accept wait one cycle even if a slot frees this cycle.
        w_accept   = vec_in_vld && (r_occ != c_occ_full);
        w_xfer     = (r_state == S_SEND) && stage_1_data_rdy;
        w_last     = w_xfer && (r_lane == c_last_lane);
        w_occ_next = r_occ + {1'b0, w_accept} - {1'b0, w_last};

        case (r_state)
            S_IDLE: begin
                // Leaving IDLE on the accept edge gives lane 0 one cycle
                // after the vector is taken.
                if (w_occ_next != c_occ_empty) begin
                    w_state_next = S_SEND;
                end
            end
            S_SEND: begin
                // A vector accepted in the same cycle as the last lane keeps
                // us in SEND so the next frame follows with no bubble.
                if (w_last && (w_occ_next == c_occ_empty)) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Occupancy, pointers, lane and frame counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_occ         <= c_occ_empty;
            r_wr_ptr      <= 1'b0;
            r_rd_ptr      <= 1'b0;
            r_lane        <= '0;
            r_frame_count <= '0;
        end else begin
            r_occ <= w_occ_next;
            if (w_accept) begin
                r_wr_ptr <= ~r_wr_ptr;
            end
            if (w_last) begin
                r_rd_ptr      <= ~r_rd_ptr;
                r_lane        <= '0;
                r_frame_count <= r_frame_count + FCNT_W'(1);
            end else if (w_xfer) begin
                r_lane <= r_lane + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Slot storage; data only, left unreset since it is never presented
    // unless a slot has been written since reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int i = 0; i < LANES; i++) begin
                r_slot[r_wr_ptr][i] <= w_lanes[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign w_lane_data      = r_slot[r_rd_ptr][r_lane];
    assign vec_in_rdy       = (r_occ != c_occ_full);
    assign stage_1_data_vld = (r_state == S_SEND);
    assign stage_1_data_fst = (r_state == S_SEND) && (r_lane == '0);
    assign stage_1_data     = (r_state == S_SEND) ? w_lane_data : '0;
    assign frame_count      = r_frame_count;
    assign busy             = (r_occ != c_occ_empty);

endmodule
`default_nettype wire

// File: tb/tb_four_12_12_st1_in_ser.sv
`default_nettype none
// ============================================================================
// Module      : tb_four_12_12_st1_in_ser
// Description : Scoreboard testbench for four_12_12_st1_in_ser. Stimulus
//               pushes the expected beats of each accepted vector into a
//               queue; a monitor pops and compares on every transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_four_12_12_st1_in_ser;

    localparam int WIDTH  = 32;
    localparam int LANES  = 12;
    localparam int FCNT_W = 16;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic             fst;
    } beat_t;

    logic                   clk = 1'b0;
    logic                   reset;
    logic [WIDTH*LANES-1:0] vec_in;
    logic                   vec_in_vld;
    logic                   vec_in_rdy;
    logic [WIDTH-1:0]       stage_1_data;
    logic                   stage_1_data_vld;
    logic                   stage_1_data_fst;
    logic                   stage_1_data_rdy;
    logic [FCNT_W-1:0]      frame_count;
    logic                   busy;

    int    checks     = 0;
    int    errors     = 0;
    int    beats_seen = 0;
    int    rdy_mode   = 0;   // 0: always ready, 1: toggle, 2: stalled
    beat_t q[$];

    always #5 clk = ~clk;

    four_12_12_st1_in_ser #(
        .WIDTH (WIDTH),
        .LANES (LANES),
        .CNT_W (4),
        .FCNT_W(FCNT_W)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .vec_in          (vec_in),
        .vec_in_vld      (vec_in_vld),
        .vec_in_rdy      (vec_in_rdy),
        .stage_1_data    (stage_1_data),
        .stage_1_data_vld(stage_1_data_vld),
        .stage_1_data_fst(stage_1_data_fst),
        .stage_1_data_rdy(stage_1_data_rdy),
        .frame_count     (frame_count),
        .busy            (busy)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Downstream ready driver.
    initial begin
        stage_1_data_rdy = 1'b1;
        forever begin
            @(negedge clk);
            case (rdy_mode)
                0:       stage_1_data_rdy = 1'b1;
                1:       stage_1_data_rdy = ~stage_1_data_rdy;
                default: stage_1_data_rdy = 1'b0;
            endcase
        end
    end

    // Monitor: samples away from the active edge.
    initial begin : mon
        logic             prev_stall;
        logic [WIDTH-1:0] prev_data;
        logic             prev_fst;
        beat_t            exp_b;
        prev_stall = 1'b0;
        prev_data  = '0;
        prev_fst   = 1'b0;
        forever begin
            @(negedge clk);
            #2;
            if (reset) begin
                prev_stall = 1'b0;
            end else begin
                if (stage_1_data_fst) chk("fst_implies_vld", 64'(stage_1_data_vld), 64'd1);
                if (prev_stall) begin
                    chk("hold_vld", 64'(stage_1_data_vld), 64'd1);
                    chk("hold_data", 64'(stage_1_data), 64'(prev_data));
                    chk("hold_fst", 64'(stage_1_data_fst), 64'(prev_fst));
                end
                if (stage_1_data_vld && stage_1_data_rdy) begin
                    if (q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_beat actual=%0h required=none", stage_1_data);
                    end else begin
                        exp_b = q.pop_front();
                        chk("beat_data", 64'(stage_1_data), 64'(exp_b.data));
                        chk("beat_fst", 64'(stage_1_data_fst), 64'(exp_b.fst));
                        beats_seen++;
                    end
                end
                prev_stall = stage_1_data_vld && !stage_1_data_rdy;
                prev_data  = stage_1_data;
                prev_fst   = stage_1_data_fst;
            end
        end
    end

    // Called at a negedge; returns at a negedge after the accept.
    task automatic send_vec(input logic [WIDTH-1:0] base);
        logic [WIDTH*LANES-1:0] v;
        bit                     done;
        done = 1'b0;
        for (int i = 0; i < LANES; i++) v[i*WIDTH +: WIDTH] = base + WIDTH'(i);
        vec_in     = v;
        vec_in_vld = 1'b1;
        for (int n = 0; n < 300 && !done; n++) begin
            if (vec_in_rdy) begin
                @(posedge clk);
                for (int i = 0; i < LANES; i++) q.push_back('{base + WIDTH'(i), (i == 0)});
                done = 1'b1;
            end
            @(negedge clk);
        end
        vec_in_vld = 1'b0;
        vec_in     = '1;
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout actual=0 required=1");
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        reset      = 1'b1;
        vec_in_vld = 1'b0;
        repeat (2) @(negedge clk);
        q.delete();
        reset = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int n = 0; n < 600 && !ok; n++) begin
            if (!busy && !stage_1_data_vld && q.size() == 0) ok = 1'b1;
            else @(negedge clk);
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout actual=busy required=idle");
        end
    endtask

    // Waits for first vld, then counts cycles until nbeats transfers occur.
    task automatic measure(input int nbeats, output int cycles, output int gaps, output bit saw_low);
        int start;
        cycles  = 0;
        gaps    = 0;
        saw_low = 1'b0;
        for (int n = 0; n < 50 && !stage_1_data_vld; n++) @(negedge clk);
        start = beats_seen;
        while (beats_seen < start + nbeats && cycles < 300) begin
            if (!stage_1_data_vld) gaps++;
            if (!vec_in_rdy) saw_low = 1'b1;
            @(negedge clk);
            cycles++;
        end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        int cycles;
        int gaps;
        int bad;
        bit saw_low;

        reset      = 1'b1;
        vec_in     = '0;
        vec_in_vld = 1'b0;

        // Reset state
        apply_reset();
        chk("rst_vec_in_rdy", 64'(vec_in_rdy), 64'd1);
        chk("rst_vld", 64'(stage_1_data_vld), 64'd0);
        chk("rst_fst", 64'(stage_1_data_fst), 64'd0);
        chk("rst_data", 64'(stage_1_data), 64'd0);
        chk("rst_frame_count", 64'(frame_count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);

        // 1: single frame, latency of one cycle
        rdy_mode = 0;
        send_vec(32'h1000_0000);
        chk("t1_latency_vld", 64'(stage_1_data_vld), 64'd1);
        chk("t1_latency_fst", 64'(stage_1_data_fst), 64'd1);
        chk("t1_first_data", 64'(stage_1_data), 64'h1000_0000);
        wait_idle();
        chk("t1_frame_count", 64'(frame_count), 64'd1);
        chk("t1_busy", 64'(busy), 64'd0);

        // 2: three back-to-back vectors
        apply_reset();
        fork
            begin
                send_vec(32'h2000_0000);
                send_vec(32'h2100_0000);
                send_vec(32'h2200_0000);
            end
            measure(36, cycles, gaps, saw_low);
        join
        chk("t2_cycles", 64'(cycles), 64'd36);
        chk("t2_gaps", 64'(gaps), 64'd0);
        chk("t2_rdy_dropped", 64'(saw_low), 64'd1);
        wait_idle();
        chk("t2_frame_count", 64'(frame_count), 64'd3);

        // 3: downstream ready toggling
        apply_reset();
        rdy_mode = 1;
        fork
            send_vec(32'h3000_0000);
            measure(12, cycles, gaps, saw_low);
        join
        chk("t3_cycles_23_24", 64'(cycles >= 23 && cycles <= 24), 64'd1);
        chk("t3_gaps", 64'(gaps), 64'd0);
        rdy_mode = 0;
        wait_idle();
        chk("t3_frame_count", 64'(frame_count), 64'd1);

        // 4: both slots full, stalled for 20 cycles
        apply_reset();
        rdy_mode = 2;
        @(negedge clk);
        send_vec(32'h4000_0000);
        send_vec(32'h4100_0000);
        bad = 0;
        repeat (20) begin
            if (vec_in_rdy || !stage_1_data_vld || !stage_1_data_fst ||
                stage_1_data !== 32'h4000_0000 || !busy) bad++;
            @(negedge clk);
        end
        chk("t4_stall_bad_cycles", 64'(bad), 64'd0);
        rdy_mode = 0;
        wait_idle();
        chk("t4_frame_count", 64'(frame_count), 64'd2);

        // 5: reset mid-frame with second slot full
        apply_reset();
        send_vec(32'h5000_0000);
        send_vec(32'h5100_0000);
        for (int n = 0; n < 40 && !(stage_1_data_vld && stage_1_data === 32'h5000_0005); n++)
            @(negedge clk);
        chk("t5_reached_lane5", 64'(stage_1_data), 64'h5000_0005);
        reset = 1'b1;
        @(negedge clk);
        chk("t5_vld", 64'(stage_1_data_vld), 64'd0);
        chk("t5_vec_in_rdy", 64'(vec_in_rdy), 64'd1);
        chk("t5_frame_count", 64'(frame_count), 64'd0);
        chk("t5_busy", 64'(busy), 64'd0);
        q.delete();
        reset = 1'b0;
        bad   = 0;
        repeat (3) begin
            @(negedge clk);
            if (stage_1_data_vld || stage_1_data_fst) bad++;
        end
        chk("t5_quiet_after_reset", 64'(bad), 64'd0);
        send_vec(32'h6000_0000);
        chk("t5_new_fst", 64'(stage_1_data_fst), 64'd1);
        chk("t5_new_data", 64'(stage_1_data), 64'h6000_0000);
        wait_idle();
        chk("t5_frame_count_after", 64'(frame_count), 64'd1);

        // 6: frame counter wrap
        apply_reset();
        force dut.r_frame_count = 16'hFFFF;
        @(negedge clk);
        release dut.r_frame_count;
        @(negedge clk);
        chk("t6_preset", 64'(frame_count), 64'hFFFF);
        send_vec(32'h7000_0000);
        wait_idle();
        chk("t6_wrap", 64'(frame_count), 64'd0);

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
